// File: rtl/mvu_weight_loader.sv
// ---------------------------------------------------------------------------
// mvu_weight_loader
//   Stream-to-memory writer that fills the per-PE weight memories of the MVU.
//   Incoming SIMD*TW-bit words are distributed PE-interleaved: word k goes to
//   PE (k mod PE) at address (k div PE). One load = PE*WMEM_DEPTH words.
//
// Ports
//   clock        rising-edge clock
//   aresetn      asynchronous active-low reset
//   start        one-cycle load request, honoured only in IDLE
//   in_wgt_valid input word valid
//   in_wgt_ready loader accepts a word (registered, depends on state only)
//   in_wgt_data  weight word
//   wmem_we      one-hot per-PE write enable
//   wmem_waddr   write address shared by all PEs
//   wmem_wdata   write data shared by all PEs
//   busy         high in LOAD and DONE
//   done         one-cycle pulse at load completion
//   wload_csum   (MVU_WLOAD_CHECKSUM_EN only) running XOR of accepted words
//
// Optional feature macro: MVU_WLOAD_CHECKSUM_EN
// ---------------------------------------------------------------------------
module mvu_weight_loader #(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1
) (
  input  logic                    clock,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    in_wgt_valid,
  output logic                    in_wgt_ready,
  input  logic [SIMD*TW-1:0]      in_wgt_data,
  output logic [PE-1:0]           wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    busy,
  output logic                    done
`ifdef MVU_WLOAD_CHECKSUM_EN
  ,
  output logic [SIMD*TW-1:0]      wload_csum
`endif
);

  localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;
  localparam int DW    = SIMD * TW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_clr;
  logic                    w_hs;
  logic                    w_pe_last;
  logic                    w_addr_last;
  logic [PE_BW-1:0]        r_pe_cnt;
  logic [WMEM_ADDR_BW-1:0] r_addr_cnt;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic [PE-1:0]           r_we;
  logic [WMEM_ADDR_BW-1:0] r_waddr;
  logic [DW-1:0]           r_wdata;

  // Decode a PE index into its one-hot write-enable vector.
  function automatic logic [PE-1:0] f_onehot(input logic [PE_BW-1:0] idx);
    logic [PE-1:0] v;
    v = {PE{1'b0}};
    for (int i = 0; i < PE; i++) begin
      if (idx == PE_BW'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // ready is a registered copy of (state == LOAD), so the handshake never
  // depends combinationally on in_wgt_valid.
  assign w_hs        = in_wgt_valid & r_ready;
  assign w_pe_last   = (r_pe_cnt == PE_BW'(PE - 1));
  assign w_addr_last = (r_addr_cnt == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

  // Next-state logic; w_clr marks an honoured start.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_hs && w_pe_last && w_addr_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_LOAD);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // PE-interleaved counters: pe_cnt runs fastest, addr_cnt steps on PE wrap.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_pe_cnt   <= {PE_BW{1'b0}};
      r_addr_cnt <= {WMEM_ADDR_BW{1'b0}};
    end else if (w_clr) begin
      r_pe_cnt   <= {PE_BW{1'b0}};
      r_addr_cnt <= {WMEM_ADDR_BW{1'b0}};
    end else if (w_hs) begin
      if (w_pe_last) begin
        r_pe_cnt   <= {PE_BW{1'b0}};
        r_addr_cnt <= w_addr_last ? {WMEM_ADDR_BW{1'b0}} : (r_addr_cnt + WMEM_ADDR_BW'(1));
      end else begin
        r_pe_cnt   <= r_pe_cnt + PE_BW'(1);
        r_addr_cnt <= r_addr_cnt;
      end
    end else begin
      r_pe_cnt   <= r_pe_cnt;
      r_addr_cnt <= r_addr_cnt;
    end
  end

  // Memory write port: enable pulses per handshake, address/data hold otherwise.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_we    <= {PE{1'b0}};
      r_waddr <= {WMEM_ADDR_BW{1'b0}};
      r_wdata <= {DW{1'b0}};
    end else if (w_hs) begin
      r_we    <= f_onehot(r_pe_cnt);
      r_waddr <= r_addr_cnt;
      r_wdata <= in_wgt_data;
    end else begin
      r_we    <= {PE{1'b0}};
      r_waddr <= r_waddr;
      r_wdata <= r_wdata;
    end
  end

`ifdef MVU_WLOAD_CHECKSUM_EN
  logic [DW-1:0] r_csum;

  // Running XOR of the words accepted in the current load.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_csum <= {DW{1'b0}};
    end else if (w_clr) begin
      r_csum <= {DW{1'b0}};
    end else if (w_hs) begin
      r_csum <= r_csum ^ in_wgt_data;
    end else begin
      r_csum <= r_csum;
    end
  end

  assign wload_csum = r_csum;
`endif

  assign in_wgt_ready = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign wmem_we      = r_we;
  assign wmem_waddr   = r_waddr;
  assign wmem_wdata   = r_wdata;

endmodule

// File: tb/tb_mvu_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_mvu_weight_loader
//   Directed bench for mvu_weight_loader with PE=2, SIMD=2, TW=4, DEPTH=4.
//   A small memory model captures the write port the way the real per-PE
//   memories would; its contents are compared against the words streamed in.
//   Optional feature macro: MVU_WLOAD_CHECKSUM_EN
// ---------------------------------------------------------------------------
module tb_mvu_weight_loader;

  localparam int PE    = 2;
  localparam int SIMD  = 2;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int NW    = PE * DEPTH;

  logic       clock;
  logic       aresetn;
  logic       start;
  logic       in_wgt_valid;
  logic       in_wgt_ready;
  logic [7:0] in_wgt_data;
  logic [1:0] wmem_we;
  logic [1:0] wmem_waddr;
  logic [7:0] wmem_wdata;
  logic       busy;
  logic       done;
`ifdef MVU_WLOAD_CHECKSUM_EN
  logic [7:0] wload_csum;
`endif

  int         n_total;
  int         n_bad;
  logic [7:0] words [NW];
  logic [7:0] mem [PE][DEPTH];
  int         n_wr;
  int         n_done;
  int         n_multi;
  int         run;

  mvu_weight_loader #(
    .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH)
  ) dut (
    .clock        (clock),
    .aresetn      (aresetn),
    .start        (start),
    .in_wgt_valid (in_wgt_valid),
    .in_wgt_ready (in_wgt_ready),
    .in_wgt_data  (in_wgt_data),
    .wmem_we      (wmem_we),
    .wmem_waddr   (wmem_waddr),
    .wmem_wdata   (wmem_wdata),
    .busy         (busy),
    .done         (done)
`ifdef MVU_WLOAD_CHECKSUM_EN
    ,
    .wload_csum   (wload_csum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model and activity counters, sampled at the capturing edge.
  always @(posedge clock) begin
    if (wmem_we[0]) mem[0][wmem_waddr] <= wmem_wdata;
    if (wmem_we[1]) mem[1][wmem_waddr] <= wmem_wdata;
    if (|wmem_we) n_wr <= n_wr + 1;
    if (wmem_we == 2'b11) n_multi <= n_multi + 1;
    if (done) n_done <= n_done + 1;
    run <= (|wmem_we) ? run + 1 : 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_words(input logic [7:0] base);
    for (int k = 0; k < NW; k++) words[k] = base + 8'(k);
  endtask

  // Called at a negedge; leaves the bench at the negedge after start's edge.
  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_rdy"},  32'(in_wgt_ready), 32'd1);
  endtask

  // Streams words[]; optional idle gap after each word and a start pulse
  // alongside word index start_at. Ends at the negedge after the final
  // handshake edge.
  task automatic stream(input bit gap, input int start_at);
    for (int k = 0; k < NW; k++) begin
      in_wgt_valid = 1'b1;
      in_wgt_data  = words[k];
      start        = (k == start_at);
      @(negedge clock);
      start = 1'b0;
      if (gap && k != NW - 1) begin
        in_wgt_valid = 1'b0;
        in_wgt_data  = 8'hFF;
        @(negedge clock);
      end
    end
    in_wgt_valid = 1'b0;
  endtask

  // Final-write / done cycle, then the return to IDLE one cycle later.
  task automatic check_end(input string tag);
    check_eq({tag, "_done"},  32'(done), 32'd1);
    check_eq({tag, "_we"},    32'(wmem_we), 32'h2);
    check_eq({tag, "_waddr"}, 32'(wmem_waddr), 32'h3);
    check_eq({tag, "_wdata"}, 32'(wmem_wdata), 32'(words[NW-1]));
    check_eq({tag, "_rdy"},   32'(in_wgt_ready), 32'd0);
    check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
    @(negedge clock);
    check_eq({tag, "_done0"}, 32'(done), 32'd0);
    check_eq({tag, "_busy0"}, 32'(busy), 32'd0);
    check_eq({tag, "_we0"},   32'(wmem_we), 32'h0);
  endtask

  task automatic check_mem(input string tag);
    for (int p = 0; p < PE; p++)
      for (int a = 0; a < DEPTH; a++)
        check_eq($sformatf("%s_mem_pe%0d_a%0d", tag, p, a), 32'(mem[p][a]), 32'(words[a*PE+p]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"},   32'(in_wgt_ready), 32'd0);
    check_eq({tag, "_we"},    32'(wmem_we), 32'h0);
    check_eq({tag, "_waddr"}, 32'(wmem_waddr), 32'h0);
    check_eq({tag, "_wdata"}, 32'(wmem_wdata), 32'h0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
  endtask

  initial begin
    int wr0;
    int dn0;
    int bad_rdy;
    int bad_we;
    n_total = 0;
    n_bad   = 0;
    n_wr    = 0;
    n_done  = 0;
    n_multi = 0;
    run     = 0;
    aresetn      = 1'b0;
    start        = 1'b0;
    in_wgt_valid = 1'b0;
    in_wgt_data  = 8'h00;

    // Reset state
    #12;
    check_reset_outputs("rst");
    @(negedge clock);
    aresetn = 1'b1;
    @(negedge clock);
    check_reset_outputs("idle");

    // 1: back-to-back stream 0x00..0x07
    fill_words(8'h00);
    wr0 = n_wr; dn0 = n_done;
    do_start("t1");
    stream(1'b0, -1);
`ifdef MVU_WLOAD_CHECKSUM_EN
    check_eq("t1_csum", 32'(wload_csum), 32'h00);
`endif
    check_end("t1");
    check_eq("t1_run", 32'(run), 32'd8);
    check_eq("t1_nwr", 32'(n_wr - wr0), 32'd8);
    check_eq("t1_ndone", 32'(n_done - dn0), 32'd1);
    check_mem("t1");

    // 2: valid toggling 1-0-1-0
    fill_words(8'h30);
    wr0 = n_wr; dn0 = n_done;
    do_start("t2");
    stream(1'b1, -1);
    check_end("t2");
    check_eq("t2_run", 32'(run), 32'd1);
    check_eq("t2_nwr", 32'(n_wr - wr0), 32'd8);
    check_eq("t2_ndone", 32'(n_done - dn0), 32'd1);
    check_mem("t2");

    // 3: start pulse after 3 accepted words is ignored
    fill_words(8'h40);
    wr0 = n_wr; dn0 = n_done;
    do_start("t3");
    stream(1'b0, 3);
    check_end("t3");
    check_eq("t3_nwr", 32'(n_wr - wr0), 32'd8);
    check_eq("t3_ndone", 32'(n_done - dn0), 32'd1);
    check_mem("t3");

    // 4: reset after 5 words, then full reload 0x10..0x17
    do_start("t4a");
    for (int k = 0; k < 5; k++) begin
      in_wgt_valid = 1'b1;
      in_wgt_data  = 8'h50 + 8'(k);
      @(negedge clock);
    end
    in_wgt_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("t4_rst");
    @(negedge clock);
    aresetn = 1'b1;
    fill_words(8'h10);
    wr0 = n_wr; dn0 = n_done;
    do_start("t4b");
    stream(1'b0, -1);
    check_end("t4");
    check_eq("t4_nwr", 32'(n_wr - wr0), 32'd8);
    check_eq("t4_ndone", 32'(n_done - dn0), 32'd1);
    check_mem("t4");

    // 5: valid without start, then start and valid together
    wr0 = n_wr;
    bad_rdy = 0; bad_we = 0;
    in_wgt_valid = 1'b1;
    in_wgt_data  = 8'hA5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (in_wgt_ready) bad_rdy++;
      if (|wmem_we) bad_we++;
    end
    check_eq("t5_idle_rdy", 32'(bad_rdy), 32'd0);
    check_eq("t5_idle_we", 32'(bad_we), 32'd0);
    check_eq("t5_idle_nwr", 32'(n_wr - wr0), 32'd0);
    fill_words(8'h20);
    in_wgt_data = words[0];
    do_start("t5");
    check_eq("t5_first_we", 32'(wmem_we), 32'h0);
    check_eq("t5_first_nwr", 32'(n_wr - wr0), 32'd0);
    dn0 = n_done;
    stream(1'b0, -1);
    check_end("t5");
    check_eq("t5_nwr", 32'(n_wr - wr0), 32'd8);
    check_eq("t5_ndone", 32'(n_done - dn0), 32'd1);
    check_mem("t5");

    // 6: checksum pattern 0x01,0x00..0x00
    for (int k = 0; k < NW; k++) words[k] = 8'h00;
    words[0] = 8'h01;
    do_start("t6");
    stream(1'b0, -1);
`ifdef MVU_WLOAD_CHECKSUM_EN
    check_eq("t6_csum", 32'(wload_csum), 32'h01);
`endif
    check_end("t6");
`ifdef MVU_WLOAD_CHECKSUM_EN
    check_eq("t6_csum_hold", 32'(wload_csum), 32'h01);
`endif
    check_mem("t6");
    check_eq("onehot_we", 32'(n_multi), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mvu_weight_loader.md
# mvu_weight_loader

Stream-to-memory writer that fills the per-PE weight memories of the MVU before computation starts. Accepts a valid/ready stream of SIMD*TW-bit weight words, distributes them across PE memories in PE-interleaved order, and generates write address, per-PE write enables and write data. It is the write side of the per-PE weight memories, which the MVU datapath reads during computation.

## Interface

Parameters:
- PE, 2, number of processing elements (weight memories driven)
- SIMD, 2, weights per memory word
- TW, 1, bits per weight
- WMEM_DEPTH, 4, words per PE memory
- WMEM_ADDR_BW, max($clog2(WMEM_DEPTH),1), address width

Ports:
- clock  input  1  rising-edge clock
- aresetn  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load (honoured only in IDLE)
- in_wgt_valid  input  1  input word valid
- in_wgt_ready  output  1  loader accepts a word this cycle
- in_wgt_data  input  SIMD*TW  weight word
- wmem_we  output  PE  one-hot write enable, bit p selects memory of PE p
- wmem_waddr  output  WMEM_ADDR_BW  write address, shared by all PEs
- wmem_wdata  output  SIMD*TW  write data, shared by all PEs
- busy  output  1  high in LOAD and DONE
- done  output  1  one-cycle pulse: load complete

## Operation

- FSM states: IDLE, LOAD, DONE.
  - IDLE: in_wgt_ready=0. start=1 -> LOAD; counters cleared.
  - LOAD: in_wgt_ready=1. Each handshake (valid & ready at an edge) writes one word, then advances counters. Handshake of final word (addr=WMEM_DEPTH-1, pe=PE-1) -> DONE.
  - DONE: one cycle, done=1, in_wgt_ready=0 -> IDLE.
- Counters: pe_cnt 0..PE-1, addr_cnt 0..WMEM_DEPTH-1. Per handshake pe_cnt increments; at PE-1 it wraps to 0 and addr_cnt increments. Word k goes to PE (k mod PE), address (k div PE). Total words per load = PE*WMEM_DEPTH.
- Per handshake: wmem_we <= one-hot(pe_cnt), wmem_waddr <= addr_cnt, wmem_wdata <= in_wgt_data; otherwise wmem_we <= 0 (waddr/wdata hold).
- No handshake (valid=0) in LOAD: counters hold, no write; stalls of any length allowed.
- start outside IDLE: ignored; no restart of an in-progress load.
- start and valid simultaneously in IDLE: start honoured, word not accepted (ready=0).
- PE=1: pe_cnt constant 0, wmem_we[0] per handshake. WMEM_DEPTH=1: addr stays 0.
- Reset mid-load: immediate return to IDLE, counters 0, wmem_we=0; partially written memory content is undefined; a new start reloads from word 0.

## Timing

- Reset values: in_wgt_ready=0, wmem_we=0, wmem_waddr=0, wmem_wdata=0, busy=0, done=0; state IDLE.
- start sampled at edge E: busy=1, in_wgt_ready=1 from E onward.
- Handshake at edge N: wmem_we/waddr/wdata valid during cycle N..N+1; memory captures at edge N+1. Write latency one cycle.
- Sustained throughput one word per cycle.
- Final handshake at edge F: cycle after F shows final wmem_we and done=1 together; in_wgt_ready=0 from F; busy=0 and state IDLE from F+1.
- in_wgt_ready depends only on state (registered), not on in_wgt_valid.

## Configuration

- MVU_WLOAD_CHECKSUM_EN defined: extra output wload_csum (SIMD*TW bits), running XOR of all words accepted in the current load; cleared to 0 on reset and on honoured start; updated at each handshake edge; final value stable from cycle with done=1 until next honoured start.
- Undefined: port and logic absent; behaviour otherwise identical.

## Test plan

- PE=2, SIMD=2, TW=4, DEPTH=4; start, stream 0x00..0x07 with valid held high -> PE0 gets addr0..3 = 0x00,0x02,0x04,0x06, PE1 gets 0x01,0x03,0x05,0x07; done one cycle after 8th handshake; 8 consecutive write cycles.
- Same load with valid toggled 1-0-1-0 -> identical memory contents, no write in idle cycles, done after 8th accepted word.
- start pulsed in LOAD after 3 words -> ignored; load completes after 8 total words; done pulses once.
- aresetn low after 5 words, then start and full reload 0x10..0x17 -> all outputs reset immediately; final contents reflect only 0x10..0x17.
- valid=1 with no start -> in_wgt_ready=0, wmem_we=0 for 20 cycles; start with valid in same cycle -> first word accepted on following edge only.
- MVU_WLOAD_CHECKSUM_EN defined, stream 0x00..0x07 -> wload_csum=0x00 at done; stream 0x01,0..0 -> wload_csum=0x01.
